// File: rtl/parity_sweep_ctrl.sv
// Walks a Gray-code sequence through an external parity unit and counts vectors whose returned parity is wrong.
// Latency: one vector per accepted transfer; 2**WIDTH RUN cycles plus one DONE cycle with out_ready held high.
// Backpressure: out_ready=0 stalls the sweep with gray_out and par_ok held; abort ends a sweep without a done pulse.
module parity_sweep_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] gray_out,
    input  logic             par_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             par_ok,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   err_count,
    output logic [WIDTH-1:0] first_err_idx
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH:0] ONE     = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] ERR_MAX = {1'b1, {WIDTH{1'b0}}};

    logic [1:0]     state;
    logic [WIDTH:0] idx;
    logic [WIDTH:0] idx_nxt;
    logic           xfer;
    logic           last;

    function automatic logic [WIDTH-1:0] gray_of(input logic [WIDTH-1:0] n);
        return n ^ (n >> 1);
    endfunction

    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    // Parity of Gray(n) is n[0], so the expected value comes straight from idx.
    assign par_ok    = out_valid && (par_in == idx[0]);
    assign xfer      = out_valid && out_ready;
    assign last      = (idx[WIDTH-1:0] == {WIDTH{1'b1}});
    assign idx_nxt   = idx + ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            gray_out      <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= RUN;
                        idx           <= '0;
                        gray_out      <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        idx <= idx_nxt;
                        if (!par_ok) begin
                            if (err_count != ERR_MAX)
                                err_count <= err_count + ONE;
                            if (err_count == '0)
                                first_err_idx <= idx[WIDTH-1:0];
                        end
                    end
                    // Abort wins over completion; gray_out only advances while the sweep continues.
                    if (abort)
                        state <= IDLE;
                    else if (xfer && last)
                        state <= DONE;
                    else if (xfer)
                        gray_out <= gray_of(idx_nxt[WIDTH-1:0]);
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_sweep_ctrl.sv
// Scoreboard bench for parity_sweep_ctrl at WIDTH=4 with a randomized parity unit and ready pattern.
module tb_parity_sweep_ctrl;

    localparam int W = 4;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] gray_out;
    logic         par_in;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         par_ok;
    logic         busy;
    logic         done;
    logic [W:0]   err_count;
    logic [W-1:0] first_err_idx;

    int           fmode = 0;
    logic [N-1:0] fmask = '0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int g;
        int ok;
    } vec_t;

    typedef struct {
        int dn;
        int err;
        int first;
        int cycles;
    } end_t;

    vec_t vq[$];
    end_t eq[$];

    parity_sweep_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .gray_out     (gray_out),
        .par_in       (par_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .par_ok       (par_ok),
        .busy         (busy),
        .done         (done),
        .err_count    (err_count),
        .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    // Parity unit model: ideal, stuck at 0, or ideal with a per-vector fault mask.
    assign par_in = (fmode == 1) ? 1'b0 : ((^gray_out) ^ ((fmode == 2) ? fmask[gray_out] : 1'b0));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int env_parity(input int g);
        if (fmode == 1) return 0;
        if (fmode == 2) return ($countones(g) % 2) ^ int'(fmask[g]);
        return $countones(g) % 2;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_gray"}, gray_out, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_parok"}, par_ok, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_errcnt"}, err_count, 0);
        chk({tag, "_first"}, first_err_idx, 0);
    endtask

    // rdy_mode: 0 = tied high, 1 = 0,1,0,1 from the first RUN cycle, 2 = random (with random start noise).
    task automatic sweep(input int mode, input int rdy_mode, input int abort_at, input int reset_at);
        int n_xfer;
        int err;
        int first;
        int cyc;
        int cnt;
        int k;
        bit took;
        end_t e;
        fmode = mode;
        fmask = N'($urandom);
        n_xfer = (abort_at >= 0) ? abort_at + 1 : (reset_at >= 0) ? reset_at : N;
        err = 0;
        first = 0;
        for (int n = 0; n < n_xfer; n++) begin
            vec_t v;
            v.g = n ^ (n >> 1);
            v.ok = (env_parity(v.g) == (n % 2)) ? 1 : 0;
            if (v.ok == 0) begin
                if (err == 0) first = n;
                err++;
            end
            vq.push_back(v);
        end
        cyc = -1;
        if (abort_at >= 0 && rdy_mode == 0) cyc = abort_at + 1;
        else if (abort_at < 0 && reset_at < 0 && rdy_mode == 0) cyc = N;
        else if (abort_at < 0 && reset_at < 0 && rdy_mode == 1) cyc = 2 * N;
        e.dn = (abort_at < 0 && reset_at < 0) ? 1 : 0;
        e.err = (reset_at >= 0) ? 0 : err;
        e.first = (reset_at >= 0) ? 0 : first;
        e.cycles = cyc;
        eq.push_back(e);

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        k = 0;
        while (busy && k < 200) begin
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = (k % 2 == 1);
                default: begin
                    out_ready = 1'($urandom_range(0, 1));
                    start = 1'($urandom_range(0, 1));
                end
            endcase
            if (cnt == abort_at) begin
                out_ready = 1'b1;
                abort = 1'b1;
            end
            if (cnt == reset_at) begin
                #1 rst_n = 1'b0;
                #1 chk_zero("async_reset");
                #1 rst_n = 1'b1;
                break;
            end
            took = out_valid && out_ready;
            @(posedge clk); #1;
            if (took) cnt++;
            abort = 1'b0;
            k++;
        end
        start = 1'b0;
        abort = 1'b0;
        if (k >= 200) chk("sweep_timeout", k, 0);
        // abort in IDLE must be ignored.
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: consumes expected vectors on transfers and end-of-sweep records when busy falls.
    initial begin
        bit   prev_busy = 1'b0;
        bit   stall_prev = 1'b0;
        int   held_g = 0;
        int   held_ok = 0;
        int   run_cyc = 0;
        vec_t v;
        end_t e;
        forever begin
            @(negedge clk);
            if (stall_prev && out_valid) begin
                chk("stall_gray", gray_out, held_g);
                chk("stall_parok", par_ok, held_ok);
            end
            stall_prev = out_valid && !out_ready;
            held_g = gray_out;
            held_ok = par_ok;
            if (out_valid) run_cyc++;
            if (out_valid && out_ready) begin
                if (vq.size() == 0) begin
                    chk("unexpected_xfer", 1, 0);
                end else begin
                    v = vq.pop_front();
                    chk("vec_gray", gray_out, v.g);
                    chk("vec_parok", par_ok, v.ok);
                end
            end
            if (prev_busy && !busy) begin
                if (eq.size() == 0) begin
                    chk("unexpected_end", 1, 0);
                end else begin
                    e = eq.pop_front();
                    chk("end_done", done, e.dn);
                    chk("end_errcnt", err_count, e.err);
                    chk("end_first", first_err_idx, e.first);
                    chk("end_leftover_vecs", vq.size(), 0);
                    if (e.cycles >= 0) chk("end_run_cycles", run_cyc, e.cycles);
                end
                vq.delete();
                run_cyc = 0;
            end
            if (!prev_busy && done) chk("spurious_done", 1, 0);
            prev_busy = busy;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        #3 chk_zero("reset");
        #10 rst_n = 1'b1;
        sweep(0, 0, -1, -1);
        sweep(1, 0, -1, -1);
        sweep(0, 1, -1, -1);
        sweep(1, 0, 5, -1);
        sweep(0, 0, -1, -1);
        sweep(1, 0, -1, 9);
        sweep(0, 0, -1, -1);
        sweep(1, 0, 15, -1);
        for (int i = 0; i < 5; i++) sweep(2, 2, -1, -1);
        sweep(2, 2, int'($urandom_range(0, N - 1)), -1);
        sweep(2, 0, -1, -1);
        repeat (3) @(posedge clk);
        chk("pending_end_records", eq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
